// File: rtl/omni_arbiter_rr.sv
// omni_arbiter_rr: packet-locked round-robin merge of NUM_SLOTS producers plus a loopback slot (index NUM_SLOTS); OMNI_ARBITER_STATS_EN adds per-slot packet counters.
// Latency: first beat of a packet 2 cycles (arbitrate, then accept); following beats 1 cycle each.
// Backpressure: 2-entry output buffer; rx_TREADY decodes state/count registers only and drops while the buffer is full.
module omni_arbiter_rr #(
    parameter int NUM_SLOTS = 2,
    parameter int WIDTH     = 528,
    parameter int ID_W      = $clog2(NUM_SLOTS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [(NUM_SLOTS+1)*WIDTH-1:0] rx_TDATA,
    input  logic [NUM_SLOTS:0]             rx_TVALID,
    input  logic [NUM_SLOTS:0]             rx_TLAST,
    output logic [NUM_SLOTS:0]             rx_TREADY,
    output logic [WIDTH-1:0]               tx_TDATA,
    output logic                           tx_TLAST,
    output logic [ID_W-1:0]                tx_TID,
    output logic                           tx_TVALID,
    input  logic                           tx_TREADY
`ifdef OMNI_ARBITER_STATS_EN
    ,
    output logic [(NUM_SLOTS+1)*32-1:0]    stat_pkt_cnt
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             last;
        logic [ID_W-1:0]  id;
    } beat_t;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] rr_ptr;

    beat_t           buf_q [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    beat_t           head;

    logic [ID_W-1:0] rr_pick;
    logic            rr_found;
    int              idx;

    logic            grant_vld;
    logic            grant_last;
    logic            push;
    logic            pop;
    beat_t           push_beat;

    // Round-robin search over the regular slots, starting at rr_ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        idx      = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SLOTS;
            if (!rr_found && rx_TVALID[idx]) begin
                rr_found = 1'b1;
                rr_pick  = ID_W'(idx);
            end
        end
    end

    assign grant_vld  = rx_TVALID[grant];
    assign grant_last = rx_TLAST[grant];
    assign push       = (state == LOCKED) && grant_vld && (count != 2'd2);
    assign pop        = (count != 2'd0) && tx_TREADY;

    assign push_beat.dat  = rx_TDATA[int'(grant)*WIDTH +: WIDTH];
    assign push_beat.last = grant_last;
    assign push_beat.id   = grant;

    // Only the granted slot sees ready, and only while the buffer has room.
    always_comb begin
        rx_TREADY = '0;
        if (state == LOCKED && count != 2'd2) begin
            rx_TREADY[grant] = 1'b1;
        end
    end

    // Arbitration FSM: one IDLE cycle to pick, then hold the grant until TLAST is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        grant <= rr_pick;
                        state <= LOCKED;
                    end else if (rx_TVALID[NUM_SLOTS]) begin
                        grant <= ID_W'(NUM_SLOTS);
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (push && grant_last) begin
                        state <= IDLE;
                        // Loopback packets do not advance the rotation.
                        if (grant != ID_W'(NUM_SLOTS)) begin
                            rr_ptr <= (grant == ID_W'(NUM_SLOTS - 1)) ? '0 : grant + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry ring buffer; simultaneous push and pop keeps one beat per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= push_beat;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head      = buf_q[rd_ptr];
    assign tx_TDATA  = head.dat;
    assign tx_TLAST  = head.last;
    assign tx_TID    = head.id;
    assign tx_TVALID = (count != 2'd0);

`ifdef OMNI_ARBITER_STATS_EN
    logic [31:0] stat_cnt [NUM_SLOTS+1];

    // Count completed packets per source slot; counters wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_SLOTS; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (push && grant_last) begin
            stat_cnt[grant] <= stat_cnt[grant] + 32'd1;
        end
    end

    // Flatten the counter array onto the output bus, slot i at bits [i*32 +: 32].
    always_comb begin
        stat_pkt_cnt = '0;
        for (int i = 0; i <= NUM_SLOTS; i++) begin
            stat_pkt_cnt[i*32 +: 32] = stat_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_omni_arbiter_rr.sv
module tb_omni_arbiter_rr;

    localparam int N    = 2;
    localparam int W    = 528;
    localparam int IDW  = $clog2(N + 1);
    localparam int N4   = 4;
    localparam int W4   = 16;
    localparam int IDW4 = $clog2(N4 + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [(N+1)*W-1:0]   rx_TDATA;
    logic [N:0]           rx_TVALID;
    logic [N:0]           rx_TLAST;
    logic [N:0]           rx_TREADY;
    logic [W-1:0]         tx_TDATA;
    logic                 tx_TLAST;
    logic [IDW-1:0]       tx_TID;
    logic                 tx_TVALID;
    logic                 tx_TREADY;

    logic [(N4+1)*W4-1:0] r4_TDATA;
    logic [N4:0]          r4_TVALID;
    logic [N4:0]          r4_TLAST;
    logic [N4:0]          r4_TREADY;
    logic [W4-1:0]        t4_TDATA;
    logic                 t4_TLAST;
    logic [IDW4-1:0]      t4_TID;
    logic                 t4_TVALID;
    logic                 t4_TREADY;

`ifdef OMNI_ARBITER_STATS_EN
    logic [(N+1)*32-1:0]  stat_pkt_cnt;
    logic [(N4+1)*32-1:0] stat4_pkt_cnt;
`endif

    omni_arbiter_rr #(.NUM_SLOTS(N), .WIDTH(W), .ID_W(IDW)) dut (
        .clk(clk), .rst(rst),
        .rx_TDATA(rx_TDATA), .rx_TVALID(rx_TVALID), .rx_TLAST(rx_TLAST), .rx_TREADY(rx_TREADY),
        .tx_TDATA(tx_TDATA), .tx_TLAST(tx_TLAST), .tx_TID(tx_TID), .tx_TVALID(tx_TVALID),
        .tx_TREADY(tx_TREADY)
`ifdef OMNI_ARBITER_STATS_EN
        , .stat_pkt_cnt(stat_pkt_cnt)
`endif
    );

    omni_arbiter_rr #(.NUM_SLOTS(N4), .WIDTH(W4), .ID_W(IDW4)) dut4 (
        .clk(clk), .rst(rst),
        .rx_TDATA(r4_TDATA), .rx_TVALID(r4_TVALID), .rx_TLAST(r4_TLAST), .rx_TREADY(r4_TREADY),
        .tx_TDATA(t4_TDATA), .tx_TLAST(t4_TLAST), .tx_TID(t4_TID), .tx_TVALID(t4_TVALID),
        .tx_TREADY(t4_TREADY)
`ifdef OMNI_ARBITER_STATS_EN
        , .stat_pkt_cnt(stat4_pkt_cnt)
`endif
    );

    int checks = 0;
    int passes = 0;

    // Producer beat lists per slot of the main instance.
    logic [15:0] pd [N+1][8];
    logic        pl [N+1][8];
    int          plen   [N+1];
    int          pptr   [N+1];
    int          pstart [N+1];

    // Beats seen leaving tx: low data bits, last, tid, cycle index.
    logic [15:0] gd [64];
    logic        gl [64];
    int          gt [64];
    int          gc [64];
    int          ng;

    int          ptr_hist [64];
    int          st_hist  [64];

    logic [N:0]     fire_in;
    logic           fire_out;
    logic           prev_stall;
    logic [W-1:0]   prev_dat;
    logic           prev_last;
    logic [IDW-1:0] prev_tid;
    int             tb_cnt, max_cnt, viol_rdy, viol_stable, cyc_g;
    logic [3:0]     trdy_pat;

    task automatic clear_tb_state();
        for (int s = 0; s <= N; s++) begin
            plen[s] = 0; pptr[s] = 0; pstart[s] = 0;
        end
        fire_in = '0; fire_out = 1'b0; prev_stall = 1'b0;
        prev_dat = '0; prev_last = 1'b0; prev_tid = '0;
        tb_cnt = 0; max_cnt = 0; viol_rdy = 0; viol_stable = 0; ng = 0; cyc_g = 0;
        trdy_pat = 4'b1111;
        rx_TVALID = '0; rx_TLAST = '0; rx_TDATA = '0; tx_TREADY = 1'b0;
        r4_TVALID = '0; r4_TLAST = '0; r4_TDATA = '0; t4_TREADY = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_tb_state();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add_pkt(input int s, input int nb, input int tag);
        for (int k = 0; k < nb; k++) begin
            pd[s][plen[s]] = 16'(tag * 256 + k);
            pl[s][plen[s]] = (k == nb - 1);
            plen[s]++;
        end
    endtask

    // Drives producers/consumer for n cycles and records what leaves tx.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int s = 0; s <= N; s++) if (fire_in[s]) pptr[s]++;
            tb_cnt = tb_cnt + ((fire_in != '0) ? 1 : 0) - (fire_out ? 1 : 0);
            if (prev_stall && (tx_TDATA !== prev_dat || tx_TLAST !== prev_last || tx_TID !== prev_tid))
                viol_stable++;
            tx_TREADY = trdy_pat[cyc_g % 4];
            for (int s = 0; s <= N; s++) begin
                if (pptr[s] < plen[s] && cyc_g >= pstart[s]) begin
                    rx_TVALID[s] = 1'b1;
                    rx_TLAST[s]  = pl[s][pptr[s]];
                    rx_TDATA[s*W +: W] = W'(pd[s][pptr[s]]);
                end else begin
                    rx_TVALID[s] = 1'b0;
                    rx_TLAST[s]  = 1'b0;
                    rx_TDATA[s*W +: W] = '0;
                end
            end
            if (tb_cnt > max_cnt) max_cnt = tb_cnt;
            if (tb_cnt == 2 && rx_TREADY != '0) viol_rdy++;
            if (cyc_g < 64) begin
                ptr_hist[cyc_g] = int'(dut.rr_ptr);
                st_hist[cyc_g]  = int'(dut.state);
            end
            fire_in  = rx_TVALID & rx_TREADY;
            fire_out = tx_TVALID & tx_TREADY;
            if (fire_out && ng < 64) begin
                gd[ng] = tx_TDATA[15:0]; gl[ng] = tx_TLAST; gt[ng] = int'(tx_TID); gc[ng] = cyc_g;
                ng++;
            end
            prev_stall = tx_TVALID & ~tx_TREADY;
            prev_dat = tx_TDATA; prev_last = tx_TLAST; prev_tid = tx_TID;
            cyc_g++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_TVALID = '1; rx_TLAST = '1; rx_TDATA = '1; tx_TREADY = 1'b1;
        r4_TVALID = '1; t4_TREADY = 1'b1;
        @(negedge clk);
        checks++; if (rx_TREADY !== 3'b000) $display("FAIL reset_rx_tready got %b want 000", rx_TREADY); else passes++;
        checks++; if (tx_TVALID !== 1'b0) $display("FAIL reset_tx_tvalid got %b want 0", tx_TVALID); else passes++;
        checks++; if (tx_TLAST !== 1'b0) $display("FAIL reset_tx_tlast got %b want 0", tx_TLAST); else passes++;
        checks++; if (tx_TID !== 2'd0) $display("FAIL reset_tx_tid got %0d want 0", tx_TID); else passes++;
        checks++; if (tx_TDATA !== '0) $display("FAIL reset_tx_tdata got %h want 0", tx_TDATA[15:0]); else passes++;
        checks++; if (int'(dut.state) !== 0) $display("FAIL reset_state got %0d want 0", int'(dut.state)); else passes++;
        checks++; if (int'(dut.rr_ptr) !== 0) $display("FAIL reset_rr_ptr got %0d want 0", int'(dut.rr_ptr)); else passes++;
        checks++; if (r4_TREADY !== 5'b00000) $display("FAIL reset4_rx_tready got %b want 00000", r4_TREADY); else passes++;
        checks++; if (t4_TVALID !== 1'b0) $display("FAIL reset4_tx_tvalid got %b want 0", t4_TVALID); else passes++;
        clear_tb_state();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_t [9];
        int exp_d [9];
        int exp_c [9];
        exp_t = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        exp_d = '{'h0000, 'h0001, 'h0002, 'h1000, 'h1001, 'h1002, 'h0100, 'h0101, 'h0102};
        exp_c = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
        do_reset();
        add_pkt(0, 3, 'h00);
        add_pkt(0, 3, 'h01);
        add_pkt(1, 3, 'h10);
        run_cycles(20);
        checks++; if (ng !== 9) $display("FAIL rr_beat_count got %0d want 9", ng); else passes++;
        for (int i = 0; i < 9; i++) begin
            checks++; if (gt[i] !== exp_t[i]) $display("FAIL rr_tid[%0d] got %0d want %0d", i, gt[i], exp_t[i]); else passes++;
            checks++; if (gd[i] !== 16'(exp_d[i])) $display("FAIL rr_data[%0d] got %h want %h", i, gd[i], 16'(exp_d[i])); else passes++;
            checks++; if (gl[i] !== (i % 3 == 2)) $display("FAIL rr_last[%0d] got %b want %b", i, gl[i], (i % 3 == 2)); else passes++;
            checks++; if (gc[i] !== exp_c[i]) $display("FAIL rr_cycle[%0d] got %0d want %0d", i, gc[i], exp_c[i]); else passes++;
        end
    endtask

    task automatic test_loopback();
        int exp_t [4];
        int exp_d [4];
        int exp_c [4];
        exp_t = '{2, 2, 1, 1};
        exp_d = '{'h2000, 'h2001, 'h1100, 'h1101};
        exp_c = '{2, 3, 5, 6};
        do_reset();
        add_pkt(2, 2, 'h20);
        add_pkt(1, 2, 'h11);
        pstart[1] = 1;
        run_cycles(12);
        checks++; if (ng !== 4) $display("FAIL lb_beat_count got %0d want 4", ng); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (gt[i] !== exp_t[i]) $display("FAIL lb_tid[%0d] got %0d want %0d", i, gt[i], exp_t[i]); else passes++;
            checks++; if (gd[i] !== 16'(exp_d[i])) $display("FAIL lb_data[%0d] got %h want %h", i, gd[i], 16'(exp_d[i])); else passes++;
            checks++; if (gc[i] !== exp_c[i]) $display("FAIL lb_cycle[%0d] got %0d want %0d", i, gc[i], exp_c[i]); else passes++;
        end
        checks++; if (st_hist[3] !== 0) $display("FAIL lb_idle_state got %0d want 0", st_hist[3]); else passes++;
        checks++; if (ptr_hist[3] !== 0) $display("FAIL lb_rr_ptr got %0d want 0", ptr_hist[3]); else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        trdy_pat = 4'b1001;
        add_pkt(0, 5, 'h05);
        run_cycles(30);
        checks++; if (ng !== 5) $display("FAIL bp_beat_count got %0d want 5", ng); else passes++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (gd[i] !== 16'('h0500 + i)) $display("FAIL bp_data[%0d] got %h want %h", i, gd[i], 16'('h0500 + i)); else passes++;
            checks++; if (gl[i] !== (i == 4)) $display("FAIL bp_last[%0d] got %b want %b", i, gl[i], (i == 4)); else passes++;
            checks++; if (gt[i] !== 0) $display("FAIL bp_tid[%0d] got %0d want 0", i, gt[i]); else passes++;
        end
        checks++; if (max_cnt !== 2) $display("FAIL bp_buffer_full got %0d want 2", max_cnt); else passes++;
        checks++; if (viol_rdy !== 0) $display("FAIL bp_ready_when_full got %0d want 0", viol_rdy); else passes++;
        checks++; if (viol_stable !== 0) $display("FAIL bp_stable_when_stalled got %0d want 0", viol_stable); else passes++;
    endtask

    task automatic test_rotate4();
        int         rem [N4+1];
        logic [N4:0] f4;
        int         n4;
        int         t4 [8];
        logic       l4 [8];
        int         d4 [8];
        int         exp_t [5];
        int         exp_d [5];
        do_reset();
        rem   = '{2, 1, 1, 1, 0};
        exp_t = '{0, 1, 2, 3, 0};
        exp_d = '{2, 17, 33, 49, 1};
        f4 = '0;
        n4 = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int s = 0; s <= N4; s++) begin
                if (f4[s]) rem[s]--;
                r4_TVALID[s] = (rem[s] > 0);
                r4_TLAST[s]  = (rem[s] > 0);
                r4_TDATA[s*W4 +: W4] = W4'(s * 16 + rem[s]);
            end
            t4_TREADY = 1'b1;
            f4 = r4_TVALID & r4_TREADY;
            if (t4_TVALID && t4_TREADY && n4 < 8) begin
                t4[n4] = int'(t4_TID); l4[n4] = t4_TLAST; d4[n4] = int'(t4_TDATA);
                n4++;
            end
        end
        checks++; if (n4 !== 5) $display("FAIL rot4_beat_count got %0d want 5", n4); else passes++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (t4[i] !== exp_t[i]) $display("FAIL rot4_tid[%0d] got %0d want %0d", i, t4[i], exp_t[i]); else passes++;
            checks++; if (l4[i] !== 1'b1) $display("FAIL rot4_last[%0d] got %b want 1", i, l4[i]); else passes++;
            checks++; if (d4[i] !== exp_d[i]) $display("FAIL rot4_data[%0d] got %0d want %0d", i, d4[i], exp_d[i]); else passes++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        add_pkt(0, 1, 'h30);
        add_pkt(0, 4, 'h40);
        run_cycles(5);
        checks++; if (ptr_hist[4] !== 1) $display("FAIL mr_ptr_before got %0d want 1", ptr_hist[4]); else passes++;
        checks++; if (st_hist[4] !== 1) $display("FAIL mr_locked_before got %0d want 1", st_hist[4]); else passes++;
        @(negedge clk);
        rst = 1'b1;
        clear_tb_state();
        @(negedge clk);
        checks++; if (tx_TVALID !== 1'b0) $display("FAIL mr_tx_tvalid got %b want 0", tx_TVALID); else passes++;
        checks++; if (rx_TREADY !== 3'b000) $display("FAIL mr_rx_tready got %b want 000", rx_TREADY); else passes++;
        checks++; if (int'(dut.state) !== 0) $display("FAIL mr_state got %0d want 0", int'(dut.state)); else passes++;
        checks++; if (int'(dut.rr_ptr) !== 0) $display("FAIL mr_rr_ptr got %0d want 0", int'(dut.rr_ptr)); else passes++;
        rst = 1'b0;
        add_pkt(1, 2, 'h50);
        run_cycles(10);
        checks++; if (ng !== 2) $display("FAIL mr_beat_count got %0d want 2", ng); else passes++;
        for (int i = 0; i < 2; i++) begin
            checks++; if (gt[i] !== 1) $display("FAIL mr_tid[%0d] got %0d want 1", i, gt[i]); else passes++;
            checks++; if (gd[i] !== 16'('h5000 + i)) $display("FAIL mr_data[%0d] got %h want %h", i, gd[i], 16'('h5000 + i)); else passes++;
        end
    endtask

`ifdef OMNI_ARBITER_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (stat_pkt_cnt !== '0) $display("FAIL st_reset got %h want 0", stat_pkt_cnt); else passes++;
        add_pkt(0, 2, 'h60); add_pkt(0, 2, 'h61); add_pkt(0, 2, 'h62);
        add_pkt(1, 2, 'h70); add_pkt(1, 2, 'h71);
        run_cycles(40);
        checks++; if (stat_pkt_cnt[31:0] !== 32'd3) $display("FAIL st_slot0 got %0d want 3", stat_pkt_cnt[31:0]); else passes++;
        checks++; if (stat_pkt_cnt[63:32] !== 32'd2) $display("FAIL st_slot1 got %0d want 2", stat_pkt_cnt[63:32]); else passes++;
        checks++; if (stat_pkt_cnt[95:64] !== 32'd0) $display("FAIL st_loop got %0d want 0", stat_pkt_cnt[95:64]); else passes++;
        @(negedge clk);
        dut.stat_cnt[0] = 32'hFFFF_FFFF;
        add_pkt(0, 1, 'h63);
        run_cycles(10);
        checks++; if (stat_pkt_cnt[31:0] !== 32'd0) $display("FAIL st_wrap got %0d want 0", stat_pkt_cnt[31:0]); else passes++;
        checks++; if (stat_pkt_cnt[63:32] !== 32'd2) $display("FAIL st_slot1_after got %0d want 2", stat_pkt_cnt[63:32]); else passes++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_tb_state();
        test_reset();
        test_round_robin();
        test_loopback();
        test_backpressure();
        test_rotate4();
        test_mid_reset();
`ifdef OMNI_ARBITER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/omni_arbiter_rr.md
Name: omni_arbiter_rr

Overview:
- Packet-aware, registered successor to the combinational slot collector in the top_k datapath.
- Merges NUM_SLOTS AXI-Stream producers plus one loopback slot (index NUM_SLOTS) onto a single stream.
- Arbitration is round-robin among slots 0..NUM_SLOTS-1. The loopback slot is served only when no regular slot is valid.
- A grant is held for a whole packet (until TLAST). Output goes through a 2-entry buffer, so no rx_TREADY depends combinationally on tx_TREADY.

Parameters:
- NUM_SLOTS, 2, number of regular producer slots; the loopback slot is extra.
- WIDTH, 528, beat width in bits (512 data + 16 metadata).
- ID_W, $clog2(NUM_SLOTS+1), width of the source-slot tag.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rx_TDATA  in  (NUM_SLOTS+1)*WIDTH  slot i occupies bits [(i+1)*WIDTH-1 -: WIDTH].
- rx_TVALID  in  NUM_SLOTS+1  per-slot valid.
- rx_TLAST  in  NUM_SLOTS+1  per-slot end of packet.
- rx_TREADY  out  NUM_SLOTS+1  per-slot ready; driven from registers only.
- tx_TDATA  out  WIDTH  merged beat.
- tx_TLAST  out  1  end of packet.
- tx_TID  out  ID_W  source slot of the beat.
- tx_TVALID  out  1  output valid.
- tx_TREADY  in  1  downstream ready.
- stat_pkt_cnt  out  (NUM_SLOTS+1)*32  per-slot completed-packet counters; present only with OMNI_ARBITER_STATS_EN.

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE, rr_ptr=0, grant=0, buffer count=0.
  - rx_TREADY=0, tx_TVALID=0, tx_TLAST=0, tx_TID=0, tx_TDATA=0, stat counters=0.
- Reset mid-packet drops the in-flight packet and buffered beats with no recovery. Producers must also be reset.
- FSM state IDLE:
  - rx_TREADY is all zero.
  - If any rx_TVALID[0..NUM_SLOTS-1] is high: grant <= the first valid slot searching rr_ptr, rr_ptr+1, ..., NUM_SLOTS-1, 0, ... (modulo NUM_SLOTS), then go to LOCKED.
  - Else if rx_TVALID[NUM_SLOTS] is high: grant <= NUM_SLOTS, then go to LOCKED.
  - Else stay in IDLE.
  - The arbitration decision costs exactly one cycle.
- FSM state LOCKED:
  - rx_TREADY[grant] = (count < 2); all other ready bits are 0.
  - A beat is accepted when rx_TVALID[grant] && rx_TREADY[grant]. It is pushed as {data, last, grant}.
  - On an accepted beat with TLAST=1, go to IDLE in the next cycle.
  - When the completed packet came from a regular slot, rr_ptr <= (grant+1) mod NUM_SLOTS. A loopback packet leaves rr_ptr unchanged.
  - A valid slot other than grant is ignored until the packet ends, including the loopback slot.
- A single-beat packet (TLAST on the first beat) gives IDLE -> LOCKED -> IDLE. The minimum inter-packet gap on the input side is 1 IDLE cycle.
- Output buffer (2-entry FIFO):
  - tx_* shows the head entry; tx_TVALID = (count != 0).
  - Push and pop in the same cycle leaves count unchanged and keeps full throughput (1 beat/cycle inside a packet).
  - Pop happens when tx_TVALID && tx_TREADY.
  - When full (count=2), rx_TREADY is 0 regardless of tx_TREADY.
  - tx_TDATA/TLAST/TID stay stable while tx_TVALID=1 and tx_TREADY=0.
- Latency: first beat, from rx_TVALID rising in IDLE to tx_TVALID, is 2 cycles (arbitration cycle + acceptance cycle, visible the cycle after). Subsequent beats take 1 cycle.
- rr_ptr wraps from NUM_SLOTS-1 to 0. NUM_SLOTS=1 degenerates to slot 0 with the loopback slot as fallback.
- Packets are never interleaved on tx; the tx_TID of every beat in a packet is constant.

Optional Feature:
- OMNI_ARBITER_STATS_EN defined:
  - stat_pkt_cnt exists; slot i's 32-bit counter increments on each accepted TLAST beat from slot i.
  - Counters wrap at 2^32-1 -> 0 and reset to 0.
- Not defined: port and counters are absent. Arbitration and timing are identical in both cases.

Test Plan:
- Slots 0 and 1 continuously valid with 3-beat packets, tx_TREADY=1 -> tx_TID sequence 0,0,0,1,1,1,0,0,0; 1 idle input cycle between packets; no interleave.
- Only loopback slot 2 valid with a 2-beat packet, then slot 1 valid mid-packet -> loopback packet completes (TID 2,2), then slot 1 is granted; rr_ptr still 0 at that arbitration.
- Slot 0 streams a 5-beat packet; tx_TREADY toggles 1,0,0,1,... -> no beat lost or duplicated; rx_TREADY[0]=0 whenever count=2; tx_TDATA stable while stalled.
- Single-beat packets on all slots, NUM_SLOTS=4 -> grants rotate 0,1,2,3,0; each tx beat has tx_TLAST=1.
- rst asserted during beat 2 of a 4-beat packet -> next cycle tx_TVALID=0, rx_TREADY=0, state IDLE, rr_ptr=0; after release, a new packet on slot 1 appears with TID 1.
- OMNI_ARBITER_STATS_EN: 3 packets from slot 0 and 2 from slot 1 -> stat_pkt_cnt slot0=3, slot1=2, loopback=0; preload at 32'hFFFFFFFF then 1 packet -> 0.
